// File: rtl/frame_write_arbiter.sv
// frame_write_arbiter
//   Sole owner of the frame_cell write port. Shares it between a rasterizer
//   pixel stream (valid/ready) and a full-frame clear engine that sweeps
//   every (col,row) in raster order with a latched colour.
//
//   Optional build macro: FRAME_WRITE_BOUNDS_CHECK_EN
//     defined   -> out-of-range pixels are accepted but not written, and
//                  counted in drop_count (16 bit, saturating).
//     undefined -> pixels are written as given; drop_count port is absent.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   clear_start, clear_color    one-cycle clear request + fill colour
//   clear_busy, clear_done      sweep in progress / pulse after last write
//   px_valid, px_ready          pixel handshake (px_ready is combinational)
//   px_x, px_y, px_color        pixel address and colour
//   write_frame_width/height    registered write column / row
//   write_enable, write_data    registered write strobe / colour
//   drop_count                  discarded pixel count (macro builds only)

module frame_write_arbiter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int CW     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_start,
  input  logic [CW-1:0] clear_color,
  output logic          clear_busy,
  output logic          clear_done,
  input  logic          px_valid,
  output logic          px_ready,
  input  logic [XW-1:0] px_x,
  input  logic [YW-1:0] px_y,
  input  logic [CW-1:0] px_color,
  output logic [XW-1:0] write_frame_width,
  output logic [YW-1:0] write_frame_height,
  output logic          write_enable,
  output logic [CW-1:0] write_data
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
  ,
  output logic [15:0]   drop_count
`endif
);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic          en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } wr_t;

  localparam logic [XW-1:0] COL_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(HEIGHT - 1);

  state_t        state, state_d;
  wr_t           wr_q, wr_d;
  logic [XW-1:0] col, col_d;
  logic [YW-1:0] row, row_d;
  logic [CW-1:0] fill, fill_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          px_ok;
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
  localparam logic [31:0] W_U = WIDTH;
  localparam logic [31:0] H_U = HEIGHT;
  logic [15:0]   drops, drops_d;
`endif

  // clear_start takes priority, so the pixel is held off in that same cycle.
  assign px_ready = (state == IDLE) && !clear_start;

`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
  assign px_ok = (32'(px_x) < W_U) && (32'(px_y) < H_U);
`else
  assign px_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_q   <= '0;
      col    <= '0;
      row    <= '0;
      fill   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
      drops  <= '0;
`endif
    end else begin
      state  <= state_d;
      wr_q   <= wr_d;
      col    <= col_d;
      row    <= row_d;
      fill   <= fill_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
      drops  <= drops_d;
`endif
    end
  end

  // col/row always name the clear address currently on the write port, so
  // reaching (COL_LAST,ROW_LAST) means the final write is already visible
  // and the next edge closes the sweep.
  always_comb begin
    state_d = state;
    wr_d    = wr_q;
    wr_d.en = 1'b0;
    col_d   = col;
    row_d   = row;
    fill_d  = fill;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
    drops_d = drops;
`endif
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          fill_d  = clear_color;
          col_d   = '0;
          row_d   = '0;
          wr_d    = '{en: 1'b1, x: '0, y: '0, c: clear_color};
          busy_d  = 1'b1;
        end else if (px_valid) begin
          if (px_ok) begin
            wr_d = '{en: 1'b1, x: px_x, y: px_y, c: px_color};
          end
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
          else if (drops != 16'hFFFF) begin
            drops_d = drops + 16'd1;
          end
`endif
        end
      end
      CLEAR: begin
        if (col == COL_LAST && row == ROW_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (col == COL_LAST) begin
            col_d = '0;
            row_d = row + YW'(1);
          end else begin
            col_d = col + XW'(1);
          end
          wr_d   = '{en: 1'b1, x: col_d, y: row_d, c: fill};
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign write_enable       = wr_q.en;
  assign write_frame_width  = wr_q.x;
  assign write_frame_height = wr_q.y;
  assign write_data         = wr_q.c;
  assign clear_busy         = busy_q;
  assign clear_done         = done_q;
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
  assign drop_count         = drops;
`endif

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Bench for frame_write_arbiter on a reduced 20x12 frame so a full clear
// sweep stays short. A reference model works from the frame rules directly
// (sweep index -> (k%W, k/W), priority of clear over pixels) and predicts the
// write port every cycle; a frame image is also kept for both sides.
module tb_frame_write_arbiter;
  localparam int W  = 20;
  localparam int H  = 12;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 3;
  localparam int N  = W * H;
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_start = 1'b0;
  logic [CW-1:0] clear_color = '0;
  logic          clear_busy, clear_done;
  logic          px_valid = 1'b0;
  logic          px_ready;
  logic [XW-1:0] px_x = '0;
  logic [YW-1:0] px_y = '0;
  logic [CW-1:0] px_color = '0;
  logic [XW-1:0] write_frame_width;
  logic [YW-1:0] write_frame_height;
  logic          write_enable;
  logic [CW-1:0] write_data;
  logic [15:0]   drop_count;

  frame_write_arbiter #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .write_frame_width(write_frame_width), .write_frame_height(write_frame_height),
    .write_enable(write_enable), .write_data(write_data)
`ifdef FRAME_WRITE_BOUNDS_CHECK_EN
    , .drop_count(drop_count)
`endif
  );
`ifndef FRAME_WRITE_BOUNDS_CHECK_EN
  assign drop_count = '0;
`endif

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  bit            m_clr;
  int            m_k;
  logic [CW-1:0] m_fill;
  logic          m_we, m_busy, m_done, m_acc;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [CW-1:0] m_d;
  int            m_drops;
  logic [CW-1:0] exp_frame [H][W];
  logic [CW-1:0] dut_frame [H][W];
  int            dut_clr_wr, dut_done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clr = 0; m_k = 0; m_fill = '0; m_we = 0; m_busy = 0; m_done = 0; m_acc = 0;
    m_x = '0; m_y = '0; m_d = '0; m_drops = 0;
  endtask

  // One clock of the rules, using the inputs present before the edge.
  task automatic model_edge();
    m_we = 0; m_busy = 0; m_done = 0; m_acc = 0;
    if (m_clr) begin
      if (m_k < N) begin
        m_x = XW'(m_k % W); m_y = YW'(m_k / W); m_d = m_fill;
        m_we = 1; m_busy = 1; m_k++;
      end else begin
        m_clr = 0; m_done = 1;
      end
    end else if (clear_start) begin
      m_clr = 1; m_fill = clear_color; m_k = 1;
      m_x = '0; m_y = '0; m_d = clear_color; m_we = 1; m_busy = 1;
    end else if (px_valid) begin
      m_acc = 1;
      if (BC && (int'(px_x) >= W || int'(px_y) >= H)) begin
        if (m_drops < 65535) m_drops++;
      end else begin
        m_x = px_x; m_y = px_y; m_d = px_color; m_we = 1;
      end
    end
    if (m_we && int'(m_x) < W && int'(m_y) < H) exp_frame[m_y][m_x] = m_d;
  endtask

  task automatic tick();
    #1;
    chk("px_ready", {31'd0, px_ready}, {31'd0, !m_clr && !clear_start});
    model_edge();
    @(posedge clk);
    #1;
    chk("write_enable", {31'd0, write_enable}, {31'd0, m_we});
    chk("write_x", 32'(write_frame_width), 32'(m_x));
    chk("write_y", 32'(write_frame_height), 32'(m_y));
    chk("write_data", 32'(write_data), 32'(m_d));
    chk("clear_busy", {31'd0, clear_busy}, {31'd0, m_busy});
    chk("clear_done", {31'd0, clear_done}, {31'd0, m_done});
    if (BC) chk("drop_count", 32'(drop_count), 32'(m_drops));
    if (write_enable && int'(write_frame_width) < W && int'(write_frame_height) < H)
      dut_frame[write_frame_height][write_frame_width] = write_data;
    if (write_enable && clear_busy) dut_clr_wr++;
    if (clear_done) dut_done_cnt++;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_we"}, {31'd0, write_enable}, 32'd0);
    chk({tag, "_busy"}, {31'd0, clear_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, clear_done}, 32'd0);
    chk({tag, "_x"}, 32'(write_frame_width), 32'd0);
    chk({tag, "_y"}, 32'(write_frame_height), 32'd0);
    chk({tag, "_data"}, 32'(write_data), 32'd0);
    if (BC) chk({tag, "_drops"}, 32'(drop_count), 32'd0);
  endtask

  task automatic frame_cmp(input string tag);
    int bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (dut_frame[y][x] !== exp_frame[y][x]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  typedef struct { int x; int y; int c; } px_t;
  px_t pix [4];
  int  n;

  initial begin
    model_reset();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        exp_frame[y][x] = '0; dut_frame[y][x] = '0;
      end

    // reset state
    #3;
    chk_zero_outputs("reset");
    chk("reset_px_ready", {31'd0, px_ready}, 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;

    // four back-to-back pixels
    pix[0] = '{1, 0, 1}; pix[1] = '{2, 0, 2}; pix[2] = '{3, 0, 3}; pix[3] = '{W-1, H-1, 7};
    px_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      px_x = XW'(pix[i].x); px_y = YW'(pix[i].y); px_color = CW'(pix[i].c);
      tick();
      chk("b2b_we", {31'd0, write_enable}, 32'd1);
    end
    px_valid = 1'b0;
    tick();

    // full clear with colour 5
    dut_clr_wr = 0; dut_done_cnt = 0;
    clear_start = 1'b1; clear_color = 3'd5; tick();
    clear_start = 1'b0; clear_color = '0;
    repeat (N + 2) tick();
    chk("clear5_writes", 32'(dut_clr_wr), 32'(N));
    chk("clear5_done_pulses", 32'(dut_done_cnt), 32'd1);
    frame_cmp("clear5_frame");

    // clear_start and px_valid together: clear wins, pixel waits
    dut_clr_wr = 0;
    clear_start = 1'b1; clear_color = 3'd3;
    px_valid = 1'b1; px_x = 10'd4; px_y = 9'd2; px_color = 3'd6;
    tick();
    clear_start = 1'b0;
    n = 0;
    for (int i = 0; i < N + 10; i++) begin
      tick(); n++;
      if (m_acc) break;
    end
    px_valid = 1'b0;
    chk("held_px_accept_delay", 32'(n), 32'(N + 1));
    chk("held_px_written", 32'(dut_frame[2][4]), 32'd6);
    chk("clear3_writes", 32'(dut_clr_wr), 32'(N));
    tick();
    frame_cmp("clear3_frame");

    // second clear_start mid-sweep is ignored
    dut_clr_wr = 0; dut_done_cnt = 0;
    clear_start = 1'b1; clear_color = 3'd2; tick();
    clear_start = 1'b0;
    repeat (99) tick();
    clear_start = 1'b1; clear_color = 3'd6; tick();
    clear_start = 1'b0;
    repeat (N) tick();
    chk("ignored_restart_writes", 32'(dut_clr_wr), 32'(N));
    chk("ignored_restart_done", 32'(dut_done_cnt), 32'd1);
    frame_cmp("clear2_frame");

    // asynchronous reset mid-sweep at (5,3)
    dut_clr_wr = 0;
    clear_start = 1'b1; clear_color = 3'd4; tick();
    clear_start = 1'b0;
    repeat (3 * W + 5) tick();
    chk("midclear_x", 32'(write_frame_width), 32'd5);
    chk("midclear_y", 32'(write_frame_height), 32'd3);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero_outputs("async_rst");
    @(posedge clk); #1; rst_n = 1'b1;
    dut_clr_wr = 0;
    repeat (6) tick();
    chk("post_rst_clear_writes", 32'(dut_clr_wr), 32'd0);

    // range handling
    px_valid = 1'b1;
    px_x = XW'(W); px_y = '0; px_color = 3'd1; tick();
    px_x = '0; px_y = YW'(H); px_color = 3'd2; tick();
    px_x = XW'(W-1); px_y = YW'(H-1); px_color = 3'd3; tick();
    px_valid = 1'b0;
    chk("edge_px_written", 32'(dut_frame[H-1][W-1]), 32'd3);
    if (BC) chk("drop_count_two", 32'(drop_count), 32'd2);
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      px_valid    = ($urandom_range(0, 99) < 70);
      px_x        = XW'($urandom_range(0, W + 3));
      px_y        = YW'($urandom_range(0, H + 2));
      px_color    = CW'($urandom);
      clear_start = ($urandom_range(0, 249) == 0);
      clear_color = CW'($urandom);
      tick();
    end
    px_valid = 1'b0; clear_start = 1'b0;
    repeat (N + 2) tick();
    frame_cmp("random_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
